opb_register_master: RTL and testbench

OPB initiator that issues single-beat 32-bit register reads and writes on behalf of user logic, so that fabric state machines can program or poll OPB slave registers (e.g. `opb_register_ppc2simulink` instances at 0x0108_3200) without the PowerPC. It is the initiator end of the OPB register protocol: it raises request, waits for grant, drives select, address and data, and terminates on acknowledge, retry or timeout. Sits on the OPB_Clk domain next to the OPB arbiter.

---
 rtl/opb_master_pkg.sv | 23 ++
 rtl/opb_register_master.sv | 178 +++++++++++++++++
 tb/tb_opb_register_master.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/opb_master_pkg.sv
// Shared types and constants for the OPB register master.
package opb_master_pkg;

    // Master sequencing states
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StXfer,
        StResp
    } opb_state_e;

    // Completion status reported on rsp_status
    typedef logic [1:0] opb_status_t;

    localparam opb_status_t ST_OK    = 2'b00;
    localparam opb_status_t ST_ERR   = 2'b01;
    localparam opb_status_t ST_TOUT  = 2'b10;
    localparam opb_status_t ST_RETRY = 2'b11;

    localparam int unsigned C_MAX_RETRY_DEFAULT = 15;
    localparam int unsigned RETRY_CNT_W         = 4;

endpackage

// File: rtl/opb_register_master.sv
// Single-beat OPB initiator: request, wait for grant, select, and terminate on
// acknowledge, retry or timeout. All M_* outputs come straight from flops.
module opb_register_master
    import opb_master_pkg::*;
#(
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned C_MAX_RETRY  = C_MAX_RETRY_DEFAULT,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    // user command side
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rnw,
    input  logic [0:C_OPB_AWIDTH-1]     cmd_addr,
    input  logic [0:C_OPB_DWIDTH/8-1]   cmd_be,
    input  logic [0:C_OPB_DWIDTH-1]     cmd_data,
    output logic                        rsp_valid,
    output logic [0:C_OPB_DWIDTH-1]     rsp_data,
    output logic [1:0]                  rsp_status,
    // OPB master side
    output logic                        M_request,
    output logic                        M_select,
    output logic                        M_RNW,
    output logic [0:C_OPB_AWIDTH-1]     M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
    output logic [0:C_OPB_DWIDTH-1]     M_DBus,
    output logic                        M_busLock,
    output logic                        M_seqAddr,
    input  logic                        OPB_MGrant,
    input  logic                        OPB_xferAck,
    input  logic                        OPB_errAck,
    input  logic                        OPB_retry,
    input  logic                        OPB_timeout,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus
);

    localparam int unsigned BeW = C_OPB_DWIDTH / 8;

    opb_state_e               state_q, state_d;
    logic [RETRY_CNT_W-1:0]   retry_q, retry_d;
    opb_status_t              rsp_status_q, rsp_status_d;
    logic [0:C_OPB_DWIDTH-1]  rsp_data_q, rsp_data_d;
    logic                     cmd_take;
    logic                     xfer_d;

    logic                     cmd_rnw_q;
    logic [0:C_OPB_AWIDTH-1]  cmd_addr_q;
    logic [0:BeW-1]           cmd_be_q;
    logic [0:C_OPB_DWIDTH-1]  cmd_data_q;

    logic                     rsp_valid_q;
    logic                     m_request_q;
    logic                     m_select_q;
    logic                     m_rnw_q;
    logic [0:C_OPB_AWIDTH-1]  m_abus_q;
    logic [0:BeW-1]           m_be_q;
    logic [0:C_OPB_DWIDTH-1]  m_dbus_q;

    assign xfer_d = (state_d == StXfer);

    // Next state, retry accounting and response capture
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        cmd_take     = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cmd_take = 1'b1;
                    retry_d  = '0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (OPB_MGrant) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                // xferAck wins over retry, retry over timeout; lone errAck is ignored
                if (OPB_xferAck) begin
                    rsp_data_d   = cmd_rnw_q ? OPB_DBus : '0;
                    rsp_status_d = OPB_errAck ? ST_ERR : ST_OK;
                    state_d      = StResp;
                end else if (OPB_retry) begin
                    retry_d = retry_q + 1'b1;
                    if (retry_q == RETRY_CNT_W'(C_MAX_RETRY)) begin
                        rsp_data_d   = '0;
                        rsp_status_d = ST_RETRY;
                        state_d      = StResp;
                    end else begin
                        state_d = StReq;
                    end
                end else if (OPB_timeout) begin
                    rsp_data_d   = '0;
                    rsp_status_d = ST_TOUT;
                    state_d      = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, retry count and held response
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q      <= StIdle;
            retry_q      <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    // Command latch on acceptance
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            cmd_rnw_q  <= 1'b0;
            cmd_addr_q <= '0;
            cmd_be_q   <= '0;
            cmd_data_q <= '0;
        end else if (cmd_take) begin
            cmd_rnw_q  <= cmd_rnw;
            cmd_addr_q <= cmd_addr;
            cmd_be_q   <= cmd_be;
            cmd_data_q <= cmd_data;
        end
    end

    // Bus outputs registered from the next state; zero whenever not selected
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rsp_valid_q <= 1'b0;
            m_request_q <= 1'b0;
            m_select_q  <= 1'b0;
            m_rnw_q     <= 1'b0;
            m_abus_q    <= '0;
            m_be_q      <= '0;
            m_dbus_q    <= '0;
        end else begin
            rsp_valid_q <= (state_d == StResp);
            m_request_q <= (state_d == StReq);
            m_select_q  <= xfer_d;
            m_rnw_q     <= xfer_d & cmd_rnw_q;
            m_abus_q    <= xfer_d ? cmd_addr_q : '0;
            m_be_q      <= xfer_d ? cmd_be_q : '0;
            m_dbus_q    <= (xfer_d && !cmd_rnw_q) ? cmd_data_q : '0;
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign M_request  = m_request_q;
    assign M_select   = m_select_q;
    assign M_RNW      = m_rnw_q;
    assign M_ABus     = m_abus_q;
    assign M_BE       = m_be_q;
    assign M_DBus     = m_dbus_q;
    assign M_busLock  = 1'b0;
    assign M_seqAddr  = 1'b0;

endmodule

// File: tb/tb_opb_register_master.sv
// Bench for opb_register_master: a reactive OPB slave/arbiter model, a directed
// vector table, hand-written reset sequences and randomized transactions.
module tb_opb_register_master;

    localparam int MAX_RETRY = 15;

    typedef struct {
        logic        rnw;
        logic [0:31] addr;
        logic [0:3]  be;
        logic [0:31] data;
        int          grant_dly;  // request cycles before grant
        int          sel_dly;    // select cycles before the response
        int          n_retry;    // retry responses before the final one
        int          fin;        // 0 ack, 1 ack+errAck, 2 timeout, 3 ack+retry
    } txn_t;

    typedef struct {
        txn_t        t;
        logic [1:0]  exp_status;
        logic [0:31] exp_data;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [0:31] cmd_addr, cmd_data;
    logic [0:3]  cmd_be;
    logic        rsp_valid;
    logic [0:31] rsp_data;
    logic [1:0]  rsp_status;
    logic        M_request, M_select, M_RNW, M_busLock, M_seqAddr;
    logic [0:31] M_ABus, M_DBus;
    logic [0:3]  M_BE;
    logic        OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout;
    logic [0:31] OPB_DBus;

    int n_cmp  = 0;
    int n_fail = 0;
    bit noise_en = 1'b0;

    logic [0:31] slv_mem [logic [0:31]];
    logic [0:31] ref_mem [logic [0:31]];

    opb_register_master #(
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_MAX_RETRY  (MAX_RETRY),
        .C_FAMILY     ("virtex6")
    ) dut (
        .OPB_Clk     (clk),
        .OPB_Rst_n   (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rnw     (cmd_rnw),
        .cmd_addr    (cmd_addr),
        .cmd_be      (cmd_be),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_status  (rsp_status),
        .M_request   (M_request),
        .M_select    (M_select),
        .M_RNW       (M_RNW),
        .M_ABus      (M_ABus),
        .M_BE        (M_BE),
        .M_DBus      (M_DBus),
        .M_busLock   (M_busLock),
        .M_seqAddr   (M_seqAddr),
        .OPB_MGrant  (OPB_MGrant),
        .OPB_xferAck (OPB_xferAck),
        .OPB_errAck  (OPB_errAck),
        .OPB_retry   (OPB_retry),
        .OPB_timeout (OPB_timeout),
        .OPB_DBus    (OPB_DBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Unwritten registers read back a fixed address-derived pattern
    function automatic logic [0:31] mem_default(input logic [0:31] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [0:31] merge_be(input logic [0:31] old, input logic [0:31] nw,
                                             input logic [0:3] be);
        logic [0:31] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // Reference model: outcome of a whole transaction from the protocol rules
    task automatic predict(input txn_t t, output logic [1:0] st, output logic [0:31] dat,
                           output int att, output int lat);
        logic [0:31] cur;
        bit          exhausted;
        cur       = ref_mem.exists(t.addr) ? ref_mem[t.addr] : mem_default(t.addr);
        exhausted = (t.n_retry > MAX_RETRY);
        att       = exhausted ? MAX_RETRY + 1 : t.n_retry + 1;
        lat       = att * (t.grant_dly + t.sel_dly + 2) + 1;
        if (exhausted) begin
            st  = 2'b11;
            dat = '0;
        end else if (t.fin == 2) begin
            st  = 2'b10;
            dat = '0;
        end else begin
            st  = (t.fin == 1) ? 2'b01 : 2'b00;
            dat = t.rnw ? cur : '0;
            if (!t.rnw && t.fin != 1) ref_mem[t.addr] = merge_be(cur, t.data, t.be);
        end
    endtask

    task automatic idle_slave();
        OPB_MGrant  = 1'b0;
        OPB_xferAck = 1'b0;
        OPB_errAck  = 1'b0;
        OPB_retry   = 1'b0;
        OPB_timeout = 1'b0;
        OPB_DBus    = '0;
    endtask

    // Issue one command and play arbiter + slave until the response pulse
    task automatic run_txn(input txn_t t, input logic [1:0] exp_st, input logic [0:31] exp_dat,
                           input int exp_att, input int exp_lat);
        int          cyc, req_cyc, sel_cyc, att, reqs, sels, w;
        bit          done, prev_sel;
        logic [0:31] cur;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        idle_slave();
        cmd_valid = 1'b1;
        cmd_rnw   = t.rnw;
        cmd_addr  = t.addr;
        cmd_be    = t.be;
        cmd_data  = t.data;
        @(negedge clk);
        // scramble the command inputs so only latched values can reach the bus
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_data  = $urandom;
        cmd_be    = 4'($urandom);
        cmd_rnw   = 1'($urandom_range(0, 1));
        cyc = 1; req_cyc = 0; sel_cyc = 0; att = 0; reqs = 0; sels = 0;
        done = 1'b0; prev_sel = 1'b0;
        while (!done && cyc < 600) begin
            if (M_request) reqs++;
            if (M_select) begin
                sels++;
                if (!prev_sel) begin
                    att++;
                    sel_cyc = 0;
                end
                chk("abus", M_ABus, t.addr);
                chk("be", 32'(M_BE), 32'(t.be));
                chk("rnw", 32'(M_RNW), 32'(t.rnw));
                chk("dbus_sel", M_DBus, t.rnw ? 32'd0 : t.data);
            end else begin
                chk("dbus_idle", M_DBus, 32'd0);
            end
            if (rsp_valid) begin
                chk("rsp_status", 32'(rsp_status), 32'(exp_st));
                chk("rsp_data", rsp_data, exp_dat);
                chk("latency", 32'(cyc), 32'(exp_lat));
                done = 1'b1;
            end
            idle_slave();
            if (noise_en) OPB_DBus = $urandom;
            if (M_request) begin
                if (req_cyc == t.grant_dly) OPB_MGrant = 1'b1;
                req_cyc++;
            end else begin
                req_cyc = 0;
                if (noise_en) OPB_MGrant = 1'($urandom_range(0, 1));
            end
            if (M_select) begin
                if (sel_cyc == t.sel_dly) begin
                    if (att - 1 < t.n_retry) begin
                        OPB_retry = 1'b1;
                    end else if (t.fin == 2) begin
                        OPB_timeout = 1'b1;
                    end else begin
                        OPB_xferAck = 1'b1;
                        OPB_errAck  = (t.fin == 1);
                        OPB_retry   = (t.fin == 3);
                        cur = slv_mem.exists(M_ABus) ? slv_mem[M_ABus] : mem_default(M_ABus);
                        if (M_RNW) OPB_DBus = cur;
                        else if (t.fin != 1) slv_mem[M_ABus] = merge_be(cur, M_DBus, M_BE);
                    end
                end else if (noise_en) begin
                    OPB_errAck = 1'($urandom_range(0, 1));
                end
                sel_cyc++;
            end
            prev_sel = M_select;
            @(negedge clk);
            cyc++;
        end
        idle_slave();
        if (!done) chk("rsp_valid_seen", 32'd0, 32'd1);
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
        chk("status_hold", 32'(rsp_status), 32'(exp_st));
        chk("data_hold", rsp_data, exp_dat);
        chk("attempts", 32'(att), 32'(exp_att));
        chk("req_cycles", 32'(reqs), 32'(exp_att * (t.grant_dly + 1)));
        chk("sel_cycles", 32'(sels), 32'(exp_att * (t.sel_dly + 1)));
    endtask

    function automatic txn_t mk(input logic rnw, input logic [0:31] addr, input logic [0:3] be,
                                input logic [0:31] data, input int g, input int s,
                                input int r, input int f);
        txn_t t;
        t.rnw = rnw; t.addr = addr; t.be = be; t.data = data;
        t.grant_dly = g; t.sel_dly = s; t.n_retry = r; t.fin = f;
        return t;
    endfunction

    initial begin
        vec_t        vecs[11];
        txn_t        t;
        logic [1:0]  st;
        logic [0:31] dat;
        int          att, lat, pulses, r;

        vecs[0]  = '{mk(0, 32'h0108_3200, 4'hF, 32'hDEAD_BEEF, 3, 1, 0, 0), 2'b00, 32'h0};
        vecs[1]  = '{mk(1, 32'h0108_3200, 4'hF, 32'h0, 0, 0, 0, 0), 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{mk(0, 32'h0108_3204, 4'hF, 32'h1234_5678, 1, 0, 0, 0), 2'b00, 32'h0};
        vecs[3]  = '{mk(1, 32'h0108_3204, 4'hF, 32'h0, 0, 2, 0, 0), 2'b00, 32'h1234_5678};
        vecs[4]  = '{mk(0, 32'h0108_3208, 4'hF, 32'hCAFE_F00D, 0, 0, 2, 0), 2'b00, 32'h0};
        vecs[5]  = '{mk(1, 32'h0108_3208, 4'hF, 32'h0, 1, 0, 16, 0), 2'b11, 32'h0};
        vecs[6]  = '{mk(1, 32'h0108_3200, 4'hF, 32'h0, 0, 1, 0, 2), 2'b10, 32'h0};
        vecs[7]  = '{mk(0, 32'h0108_3200, 4'b0011, 32'hAABB_CCDD, 0, 0, 0, 1), 2'b01, 32'h0};
        vecs[8]  = '{mk(0, 32'h0108_3200, 4'b0011, 32'hAABB_CCDD, 0, 0, 0, 3), 2'b00, 32'h0};
        vecs[9]  = '{mk(1, 32'h0108_3200, 4'hF, 32'h0, 0, 0, 0, 1), 2'b01, 32'hDEAD_CCDD};
        vecs[10] = '{mk(1, 32'h0108_3208, 4'hF, 32'h0, 0, 0, 15, 0), 2'b00, 32'hCAFE_F00D};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_be = '0; cmd_data = '0;
        idle_slave();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_ctrl", {26'd0, M_request, M_select, M_RNW, rsp_valid, M_busLock, M_seqAddr},
            32'd0);
        chk("reset_abus", M_ABus, 32'd0);
        chk("reset_dbus", M_DBus, 32'd0);
        chk("reset_be", 32'(M_BE), 32'd0);
        chk("reset_rsp", rsp_data | 32'(rsp_status), 32'd0);

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            predict(vecs[i].t, st, dat, att, lat);
            run_txn(vecs[i].t, vecs[i].exp_status, vecs[i].exp_data, att, lat);
        end

        // Reset while selected: bus released at once, no response, command lost
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h0108_320C;
        cmd_be = 4'hF; cmd_data = 32'h0BAD_F00D;
        @(negedge clk);
        cmd_valid = 1'b0;
        OPB_MGrant = 1'b1;
        @(negedge clk);
        OPB_MGrant = 1'b0;
        chk("rst_mid_select_before", 32'(M_select), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_select", 32'(M_select), 32'd0);
        chk("rst_mid_request", 32'(M_request), 32'd0);
        chk("rst_mid_dbus", M_DBus, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        chk("rst_mid_no_rsp", 32'(pulses), 32'd0);
        chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
        t = mk(1, 32'h0108_3204, 4'hF, 32'h0, 0, 0, 0, 0);
        predict(t, st, dat, att, lat);
        run_txn(t, st, dat, att, lat);

        // Randomized transactions with grant and errAck noise
        noise_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            t.rnw       = 1'($urandom_range(0, 1));
            t.addr      = 32'h0108_3200 + 32'($urandom_range(0, 3)) * 32'd4;
            t.be        = 4'($urandom);
            t.data      = $urandom;
            t.grant_dly = $urandom_range(0, 3);
            t.sel_dly   = $urandom_range(0, 3);
            r           = $urandom_range(0, 7);
            t.n_retry   = (r < 5) ? 0 : (r == 5) ? 1 : (r == 6) ? 2
                        : (($urandom_range(0, 1) == 1) ? 15 : 16);
            t.fin       = $urandom_range(0, 3);
            predict(t, st, dat, att, lat);
            run_txn(t, st, dat, att, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
